serial_carry_adder: RTL
=======================

Name: serial_carry_adder

Overview:
- Multi-beat, carry-chained adder sitting directly upstream of the A1_2 adder stage's result consumers.
- Takes wide operands as a stream of W-bit limbs, least-significant limb first.
- Carries between limbs internally and emits one registered sum limb per accepted beat.
- Valid/ready on both sides, so wide adds reuse a single W-bit adder datapath across cycles.

Parameters:
- W, 8, limb width in bits.
- MAX_BEATS, 4, maximum limbs per operation; must be ≥1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  W  operand A limb.
- in_b  input  W  operand B limb.
- in_cin  input  1  carry-in, sampled only on the first beat of an operation.
- in_last  input  1  marks the most-significant limb.
- out_valid  output  1  sum beat valid.
- out_ready  input  1  downstream accepts the sum beat.
- out_sum  output  W  sum limb.
- out_beat  output  clog2(MAX_BEATS) (min 1)  limb index within the operation, 0 = LSB.
- out_last  output  1  final limb of the operation.
- out_cout  output  1  final carry-out; meaningful only when out_last=1, otherwise 0.
- out_err  output  1  operation was truncated at MAX_BEATS; meaningful only with out_last=1.
- op_count  output  CNT_W  number of completed operations (out_last beats handed off).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_sum=0, out_beat=0, out_last=0, out_cout=0, out_err=0, op_count=0.
  - Carry register=0, beat counter=0, FSM=FIRST.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output handed off when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register, no combinational path from in_* to out_*).
  - Throughput is one beat/cycle; latency is 1 cycle from accept to out_valid.
- FSM:
  - FIRST: on accept, compute {c,s} = in_a + in_b + in_cin.
  - CONT: on accept, compute {c,s} = in_a + in_b + carry_reg; in_cin is ignored.
- Every accept:
  - out_sum <= s; out_beat <= beat counter.
  - Terminating beat (see below): out_last <= 1, out_cout <= c, carry_reg <= 0, beat counter <= 0, FSM <= FIRST.
  - Otherwise: out_last <= 0, out_cout <= 0, carry_reg <= c, beat counter increments, FSM <= CONT.
- Terminating beat = in_last=1 OR beat counter == MAX_BEATS-1.
  - out_err <= (beat counter == MAX_BEATS-1) && !in_last.
  - A truncated operation ends there; the next accepted beat starts a new operation in FIRST and uses its own in_cin.
- Output hold: while out_valid && !out_ready, all out_* fields stay stable and no beat is accepted.
- out_valid clears on hand-off with no simultaneous accept; it stays 1 on hand-off plus a simultaneous accept.
- op_count increments on each hand-off with out_last=1 and wraps at 2^CNT_W to 0.
- MAX_BEATS=1: every beat is terminating; out_err=1 whenever in_last=0.
- Width rules:
  - Sum is the low W bits of the (W+1)-bit add; carry is bit W.
  - Operands are unsigned; no signed overflow flag.
- Reset mid-operation:
  - A partial operation is discarded, carry cleared, no final beat emitted.
  - The first beat after reset uses in_cin.

Test Plan:
- Single beat: a=8'hFF, b=8'h01, cin=0, last=1 -> out_sum=8'h00, out_cout=1, out_last=1, out_beat=0, out_err=0, op_count=1.
- Two beats: (a=FF, b=01, cin=1, last=0) then (a=00, b=00, cin=1 ignored, last=1).
  - Beat 0: out_sum=01, out_last=0.
  - Beat 1: out_sum=01, out_beat=1, out_cout=0 (0x00FF+0x0001+1=0x0101).
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 for those cycles; out_sum, out_beat and out_last unchanged; no beat lost or duplicated after release.
- Truncation with MAX_BEATS=4: 5 beats of a=FF, b=00, cin=1, last=0.
  - Beats 0-2: out_sum=00 each.
  - Beat 3: out_sum=00, out_last=1, out_cout=1, out_err=1.
  - Beat 4: out_beat=0, out_sum=00, carry taken from in_cin=1.
- Reset mid-op: assert rst_n=0 after beat 0 of (a=FF, b=01, cin=0) -> all outputs 0 immediately; next beat (a=01, b=01, cin=0, last=1) gives out_sum=02, out_cout=0.
- Streaming: 8 single-beat ops back-to-back with out_ready=1 -> one out_valid per cycle, no bubbles, op_count=8.

Source files
------------

// File: rtl/serial_carry_adder.sv
// Multi-beat carry-chained adder: wide operands arrive as W-bit limbs, LSB first,
// and leave as one registered sum limb per accepted beat.
module serial_carry_adder #(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [BW-1:0]    out_beat,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {StFirst, StCont} state_e;

    state_e            state_q, state_d;
    logic              carry_q, carry_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              valid_q, valid_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [BW-1:0]     obeat_q, obeat_d;
    logic              last_q, last_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              handoff;
    logic              carry_in;
    logic              at_max;
    logic              term;
    logic [W:0]        sum_full;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = valid_q && out_ready;

    always_comb begin
        carry_in = (state_q == StFirst) ? in_cin : carry_q;
        sum_full = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, carry_in};
        at_max   = (beat_q == BW'(MAX_BEATS - 1));
        term     = in_last || at_max;
    end

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        obeat_d = obeat_q;
        last_d  = last_q;
        cout_d  = cout_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (handoff && last_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept) begin
            valid_d = 1'b1;
            sum_d   = sum_full[W-1:0];
            obeat_d = beat_q;
            err_d   = at_max && !in_last;
            if (term) begin
                last_d  = 1'b1;
                cout_d  = sum_full[W];
                carry_d = 1'b0;
                beat_d  = '0;
                state_d = StFirst;
            end else begin
                last_d  = 1'b0;
                cout_d  = 1'b0;
                carry_d = sum_full[W];
                beat_d  = beat_q + BW'(1);
                state_d = StCont;
            end
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFirst;
            carry_q <= 1'b0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            obeat_q <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            obeat_q <= obeat_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_beat  = obeat_q;
    assign out_last  = last_q;
    assign out_cout  = cout_q;
    assign out_err   = err_q;
    assign op_count  = cnt_q;

endmodule
